// File: rtl/lane_rx_pkt_buffer.sv
// rtl/lane_rx_pkt_buffer.sv - store-and-forward RX frame buffer: length/keep check, drop by rewind, Sop/Eop replay
// Optional frame counters are enabled by defining RX_PKT_STAT_EN.

module lane_rx_pkt_buffer #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int LEN_AW  = 4,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522
) (
   input  logic                  SysClk,
   input  logic                  Rst,
`ifdef RX_PKT_STAT_EN
   input  logic                  CntClr,
   output logic [31:0]           GoodPktCnt,
   output logic [31:0]           DropPktCnt,
`endif
   input  logic [DATA_W-1:0]     s_axis_tdata,
   input  logic [DATA_W/8-1:0]   s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   input  logic                  RxReady,
   output logic                  RxValid,
   output logic                  RxSop,
   output logic                  RxEop,
   output logic [DATA_W-1:0]     RxData,
   output logic [DATA_W/8-1:0]   RxKeep,
   output logic [15:0]           RxLen,
   output logic                  DropPulse
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

   logic [DATA_W-1:0]   r_mem    [0:(1<<ADDR_W)-1];
   logic [15:0]         r_lf_mem [0:(1<<LEN_AW)-1];

   logic [ADDR_W-1:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr, r_rd_addr;
   logic [15:0]         r_len;
   logic                r_err;
   logic                r_drop;
   logic [LEN_AW:0]     r_lf_wr, r_lf_rd;

   state_t              r_state, w_next_state;
   logic                r_valid, r_sop, r_eop;
   logic [DATA_W-1:0]   r_data;
   logic [3:0]          r_keep, r_last_keep;
   logic [15:0]         r_out_len;
   logic [14:0]         r_remain;

   logic [2:0]          w_keep_cnt;
   logic [16:0]         w_sum;
   logic [15:0]         w_len_next;
   logic                w_last_keep_ok, w_beat_err, w_full, w_frame_err, w_len_ok;
   logic                w_lf_full, w_lf_empty, w_wr_en, w_commit, w_drop;
   logic [ADDR_W-1:0]   w_wr_inc;
   logic                w_hs, w_pop, w_load, w_finish;
   logic [15:0]         w_pop_len;
   logic [16:0]         w_pop_len_p3;

   // ---------------- write side ----------------
   assign w_keep_cnt     = {2'b0, s_axis_tkeep[0]} + {2'b0, s_axis_tkeep[1]}
                         + {2'b0, s_axis_tkeep[2]} + {2'b0, s_axis_tkeep[3]};
   assign w_sum          = {1'b0, r_len} + (s_axis_tlast ? {14'b0, w_keep_cnt} : 17'd4);
   assign w_len_next     = w_sum[16] ? 16'hFFFF : w_sum[15:0];
   assign w_last_keep_ok = (s_axis_tkeep == 4'h1) || (s_axis_tkeep == 4'h3) ||
                           (s_axis_tkeep == 4'h7) || (s_axis_tkeep == 4'hF);
   assign w_beat_err     = s_axis_tlast ? !w_last_keep_ok : (s_axis_tkeep != 4'hF);
   assign w_wr_inc       = r_wr_ptr + ADDR_W'(1);
   assign w_full         = (w_wr_inc == r_rd_ptr);
   assign w_frame_err    = r_err | w_beat_err | w_full;
   assign w_len_ok       = (w_len_next >= 16'(MIN_LEN)) && (w_len_next <= 16'(MAX_LEN));
   assign w_lf_empty     = (r_lf_wr == r_lf_rd);
   assign w_lf_full      = (r_lf_wr[LEN_AW] != r_lf_rd[LEN_AW]) &&
                           (r_lf_wr[LEN_AW-1:0] == r_lf_rd[LEN_AW-1:0]);
   // Errored beats are never written, so a full RAM is never overrun.
   assign w_wr_en        = s_axis_tvalid && !w_frame_err;
   assign w_commit       = s_axis_tvalid && s_axis_tlast && !w_frame_err && w_len_ok && !w_lf_full;
   assign w_drop         = s_axis_tvalid && s_axis_tlast && !w_commit;

   always_ff @(posedge SysClk) begin
      if (w_wr_en)  r_mem[r_wr_ptr] <= s_axis_tdata;
      if (w_commit) r_lf_mem[r_lf_wr[LEN_AW-1:0]] <= w_len_next;
   end

   always_ff @(posedge SysClk) begin
      if (Rst) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_len        <= '0;
         r_err        <= 1'b0;
         r_drop       <= 1'b0;
         r_lf_wr      <= '0;
      end else begin
         r_drop <= w_drop;
         if (w_commit) r_lf_wr <= r_lf_wr + (LEN_AW+1)'(1);
         if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
               r_len <= '0;
               r_err <= 1'b0;
               if (w_commit) begin
                  r_wr_ptr     <= w_wr_inc;
                  r_commit_ptr <= w_wr_inc;
               end else begin
                  r_wr_ptr     <= r_commit_ptr;
               end
            end else begin
               r_len <= w_len_next;
               r_err <= w_frame_err;
               if (w_wr_en) r_wr_ptr <= w_wr_inc;
            end
         end
      end
   end

   // ---------------- read side ----------------
   assign w_hs         = r_valid && RxReady;
   assign w_pop_len    = r_lf_mem[r_lf_rd[LEN_AW-1:0]];
   assign w_pop_len_p3 = {1'b0, w_pop_len} + 17'd3;

   always_ff @(posedge SysClk) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (!w_lf_empty) w_next_state = S_LOAD;
         S_LOAD: w_next_state = S_SEND;
         S_SEND: if (w_hs && r_eop) w_next_state = w_lf_empty ? S_IDLE : S_LOAD;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_pop    = 1'b0;
      w_load   = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         S_IDLE: w_pop = !w_lf_empty;
         S_LOAD: w_load = 1'b1;
         S_SEND: begin
            w_load   = w_hs && !r_eop;
            w_finish = w_hs && r_eop;
            w_pop    = w_hs && r_eop && !w_lf_empty;
         end
         default: ;
      endcase
   end

   // r_rd_addr runs one word ahead of r_rd_ptr while a beat sits in the output register.
   always_ff @(posedge SysClk) begin
      if (Rst) begin
         r_lf_rd     <= '0;
         r_rd_ptr    <= '0;
         r_rd_addr   <= '0;
         r_valid     <= 1'b0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_data      <= '0;
         r_keep      <= '0;
         r_last_keep <= '0;
         r_out_len   <= '0;
         r_remain    <= '0;
      end else begin
         if (w_hs) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         if (w_pop) begin
            r_lf_rd   <= r_lf_rd + (LEN_AW+1)'(1);
            r_out_len <= w_pop_len;
            r_remain  <= w_pop_len_p3[16:2];
            case (w_pop_len[1:0])
               2'd1:    r_last_keep <= 4'h1;
               2'd2:    r_last_keep <= 4'h3;
               2'd3:    r_last_keep <= 4'h7;
               default: r_last_keep <= 4'hF;
            endcase
         end
         if (w_load) begin
            r_data    <= r_mem[r_rd_addr];
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
            r_remain  <= r_remain - 15'd1;
            r_valid   <= 1'b1;
            r_sop     <= (r_state == S_LOAD);
            r_eop     <= (r_remain == 15'd1);
            r_keep    <= (r_remain == 15'd1) ? r_last_keep : 4'hF;
         end else if (w_finish) begin
            r_valid   <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_data    <= '0;
            r_keep    <= '0;
         end
      end
   end

`ifdef RX_PKT_STAT_EN
   logic [31:0] r_good_cnt, r_drop_cnt;

   always_ff @(posedge SysClk) begin
      if (Rst || CntClr) begin
         r_good_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_commit && (r_good_cnt != 32'hFFFF_FFFF)) r_good_cnt <= r_good_cnt + 32'd1;
         if (r_drop && (r_drop_cnt != 32'hFFFF_FFFF))   r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

   assign GoodPktCnt = r_good_cnt;
   assign DropPktCnt = r_drop_cnt;
`endif

   assign RxValid   = r_valid;
   assign RxSop     = r_sop;
   assign RxEop     = r_eop;
   assign RxData    = r_data;
   assign RxKeep    = r_keep;
   assign RxLen     = r_out_len;
   assign DropPulse = r_drop;

endmodule

// File: tb/tb_lane_rx_pkt_buffer.sv
// tb/tb_lane_rx_pkt_buffer.sv - directed self-checking bench for lane_rx_pkt_buffer
// Counter checks are compiled in when RX_PKT_STAT_EN is defined.

module tb_lane_rx_pkt_buffer;

   logic        SysClk = 1'b0;
   logic        Rst;
   logic [31:0] s_axis_tdata;
   logic [3:0]  s_axis_tkeep;
   logic        s_axis_tlast;
   logic        s_axis_tvalid;
   logic        RxReady;
   logic        RxValid, RxSop, RxEop, DropPulse;
   logic [31:0] RxData;
   logic [3:0]  RxKeep;
   logic [15:0] RxLen;
`ifdef RX_PKT_STAT_EN
   logic        CntClr;
   logic [31:0] GoodPktCnt, DropPktCnt;
`endif

   always #5 SysClk = ~SysClk;

   lane_rx_pkt_buffer dut (
      .SysClk        (SysClk),
      .Rst           (Rst),
`ifdef RX_PKT_STAT_EN
      .CntClr        (CntClr),
      .GoodPktCnt    (GoodPktCnt),
      .DropPktCnt    (DropPktCnt),
`endif
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .RxReady       (RxReady),
      .RxValid       (RxValid),
      .RxSop         (RxSop),
      .RxEop         (RxEop),
      .RxData        (RxData),
      .RxKeep        (RxKeep),
      .RxLen         (RxLen),
      .DropPulse     (DropPulse)
   );

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [3:0]  keep;
      logic [31:0] data;
      logic [15:0] len;
   } beat_t;

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    last_tl_cyc = 0;
   int    drops = 0;
   int    stall_err = 0;
   int    valid_cnt = 0;
   int    rise_cyc = -1;
   logic  prev_stall = 1'b0;
   logic  prev_valid = 1'b0;
   beat_t prev_b = '0;
   beat_t w_cur;
   beat_t cap_q[$];

   assign w_cur = {RxSop, RxEop, RxKeep, RxData, RxLen};

   always @(posedge SysClk) cyc <= cyc + 1;

   always @(negedge SysClk) begin
      if (Rst) begin
         prev_stall <= 1'b0;
         prev_valid <= 1'b0;
      end else begin
         if (DropPulse) drops <= drops + 1;
         if (RxValid) valid_cnt <= valid_cnt + 1;
         if (RxValid && !prev_valid) rise_cyc <= cyc;
         if (prev_stall && (!RxValid || (w_cur !== prev_b))) stall_err <= stall_err + 1;
         if (RxValid && RxReady) cap_q.push_back(w_cur);
         prev_stall <= RxValid && !RxReady;
         prev_b     <= w_cur;
         prev_valid <= RxValid;
      end
   end

   function automatic logic [31:0] exp_word(input int id, input int b);
      return {id[7:0], 8'h5A, b[15:0]};
   endfunction

   function automatic logic [3:0] keep_of(input int n);
      case (n % 4)
         1:       return 4'h1;
         2:       return 4'h3;
         3:       return 4'h7;
         default: return 4'hF;
      endcase
   endfunction

   task automatic do_reset();
      Rst = 1'b1;
      repeat (3) @(posedge SysClk);
      #1;
      Rst = 1'b0;
   endtask

   task automatic send_frame(input int n, input int id);
      int nb;
      nb = (n + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = exp_word(id, b);
         s_axis_tlast  = (b == nb - 1);
         s_axis_tkeep  = (b == nb - 1) ? keep_of(n) : 4'hF;
         if (b == nb - 1) last_tl_cyc = cyc;
         @(posedge SysClk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tkeep  = 4'h0;
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int i = 0; i < budget && cap_q.size() < n; i++) begin
         @(posedge SysClk);
         #1;
      end
   endtask

   task automatic test_reset();
      total++; if (RxValid !== 1'b0) begin bad++; $display("FAIL reset_RxValid got=%0h exp=0", RxValid); end
      total++; if (RxSop !== 1'b0) begin bad++; $display("FAIL reset_RxSop got=%0h exp=0", RxSop); end
      total++; if (RxEop !== 1'b0) begin bad++; $display("FAIL reset_RxEop got=%0h exp=0", RxEop); end
      total++; if (RxData !== 32'h0) begin bad++; $display("FAIL reset_RxData got=%h exp=0", RxData); end
      total++; if (RxKeep !== 4'h0) begin bad++; $display("FAIL reset_RxKeep got=%h exp=0", RxKeep); end
      total++; if (RxLen !== 16'h0) begin bad++; $display("FAIL reset_RxLen got=%h exp=0", RxLen); end
      total++; if (DropPulse !== 1'b0) begin bad++; $display("FAIL reset_DropPulse got=%0h exp=0", DropPulse); end
`ifdef RX_PKT_STAT_EN
      total++; if (GoodPktCnt !== 32'h0) begin bad++; $display("FAIL reset_GoodPktCnt got=%0d exp=0", GoodPktCnt); end
      total++; if (DropPktCnt !== 32'h0) begin bad++; $display("FAIL reset_DropPktCnt got=%0d exp=0", DropPktCnt); end
`endif
   endtask

   task automatic test_frame_64();
      int base, d0;
      beat_t e;
      base = cap_q.size();
      d0   = drops;
      RxReady = 1'b1;
      send_frame(64, 1);
      wait_beats(base + 16, 200);
      total++; if (cap_q.size() != base + 16) begin bad++; $display("FAIL f64_count got=%0d exp=16", cap_q.size() - base); end
      total++; if (rise_cyc - last_tl_cyc != 3) begin bad++; $display("FAIL f64_latency got=%0d exp=3", rise_cyc - last_tl_cyc); end
      for (int b = 0; b < 16 && base + b < cap_q.size(); b++) begin
         e = {b == 0, b == 15, 4'hF, exp_word(1, b), 16'd64};
         total++;
         if (cap_q[base + b] !== e) begin bad++; $display("FAIL f64_beat b=%0d got=%h exp=%h", b, cap_q[base + b], e); end
      end
      total++; if (drops != d0) begin bad++; $display("FAIL f64_drops got=%0d exp=0", drops - d0); end
   endtask

   task automatic test_frame_65();
      int base;
      beat_t e;
      base = cap_q.size();
      send_frame(65, 2);
      wait_beats(base + 17, 200);
      total++; if (cap_q.size() != base + 17) begin bad++; $display("FAIL f65_count got=%0d exp=17", cap_q.size() - base); end
      for (int b = 0; b < 17 && base + b < cap_q.size(); b++) begin
         e = {b == 0, b == 16, (b == 16) ? 4'h1 : 4'hF, exp_word(2, b), 16'd65};
         total++;
         if (cap_q[base + b] !== e) begin bad++; $display("FAIL f65_beat b=%0d got=%h exp=%h", b, cap_q[base + b], e); end
      end
   endtask

   task automatic test_back_to_back();
      int base, d0, nexp, idx, nb;
      beat_t e;
      base = cap_q.size();
      d0   = drops;
      nexp = 0;
      for (int f = 0; f < 10; f++) nexp += (64 + f + 3) / 4;
      for (int f = 0; f < 10; f++) send_frame(64 + f, 10 + f);
      wait_beats(base + nexp, 800);
      total++; if (cap_q.size() != base + nexp) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", cap_q.size() - base, nexp); end
      idx = base;
      for (int f = 0; f < 10; f++) begin
         nb = (64 + f + 3) / 4;
         for (int b = 0; b < nb && idx < cap_q.size(); b++) begin
            e = {b == 0, b == nb - 1, (b == nb - 1) ? keep_of(64 + f) : 4'hF, exp_word(10 + f, b), 16'(64 + f)};
            total++;
            if (cap_q[idx] !== e) begin bad++; $display("FAIL b2b_beat f=%0d b=%0d got=%h exp=%h", f, b, cap_q[idx], e); end
            idx++;
         end
      end
      total++; if (drops != d0) begin bad++; $display("FAIL b2b_drops got=%0d exp=0", drops - d0); end
   endtask

   task automatic test_runt_oversize();
      int base, d0;
      beat_t e;
      base = cap_q.size();
      d0   = drops;
`ifdef RX_PKT_STAT_EN
      CntClr = 1'b1;
      @(posedge SysClk);
      #1;
      CntClr = 1'b0;
`endif
      send_frame(60, 30);
      send_frame(1600, 31);
      send_frame(64, 32);
      wait_beats(base + 16, 200);
      repeat (30) @(posedge SysClk);
      #1;
      total++; if (cap_q.size() != base + 16) begin bad++; $display("FAIL drop_count got=%0d exp=16", cap_q.size() - base); end
      for (int b = 0; b < 16 && base + b < cap_q.size(); b++) begin
         e = {b == 0, b == 15, 4'hF, exp_word(32, b), 16'd64};
         total++;
         if (cap_q[base + b] !== e) begin bad++; $display("FAIL drop_beat b=%0d got=%h exp=%h", b, cap_q[base + b], e); end
      end
      total++; if (drops - d0 != 2) begin bad++; $display("FAIL drop_pulses got=%0d exp=2", drops - d0); end
`ifdef RX_PKT_STAT_EN
      total++; if (DropPktCnt !== 32'd2) begin bad++; $display("FAIL drop_DropPktCnt got=%0d exp=2", DropPktCnt); end
      total++; if (GoodPktCnt !== 32'd1) begin bad++; $display("FAIL drop_GoodPktCnt got=%0d exp=1", GoodPktCnt); end
`endif
   endtask

   task automatic test_fill();
      int base, d0, idx, nb;
      beat_t e;
      base = cap_q.size();
      d0   = drops;
      RxReady = 1'b0;
      for (int f = 0; f < 4; f++) send_frame(1100, 40 + f);
      repeat (10) @(posedge SysClk);
      #1;
      total++; if (drops - d0 != 1) begin bad++; $display("FAIL fill_drops got=%0d exp=1", drops - d0); end
      total++; if (cap_q.size() != base) begin bad++; $display("FAIL fill_stalled got=%0d exp=0", cap_q.size() - base); end
      RxReady = 1'b1;
      wait_beats(base + 825, 2000);
      total++; if (cap_q.size() != base + 825) begin bad++; $display("FAIL fill_drain got=%0d exp=825", cap_q.size() - base); end
      idx = base;
      nb  = 275;
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < nb && idx < cap_q.size(); b++) begin
            e = {b == 0, b == nb - 1, 4'hF, exp_word(40 + f, b), 16'd1100};
            total++;
            if (cap_q[idx] !== e) begin bad++; $display("FAIL fill_beat f=%0d b=%0d got=%h exp=%h", f, b, cap_q[idx], e); end
            idx++;
         end
      end
      base = cap_q.size();
      send_frame(64, 44);
      wait_beats(base + 16, 200);
      total++; if (cap_q.size() != base + 16) begin bad++; $display("FAIL fill_next_count got=%0d exp=16", cap_q.size() - base); end
      for (int b = 0; b < 16 && base + b < cap_q.size(); b++) begin
         e = {b == 0, b == 15, 4'hF, exp_word(44, b), 16'd64};
         total++;
         if (cap_q[base + b] !== e) begin bad++; $display("FAIL fill_next_beat b=%0d got=%h exp=%h", b, cap_q[base + b], e); end
      end
      total++; if (drops - d0 != 1) begin bad++; $display("FAIL fill_next_drops got=%0d exp=1", drops - d0); end
   endtask

   task automatic test_random_ready();
      int base, s0;
      beat_t e;
      base = cap_q.size();
      s0   = stall_err;
      fork
         send_frame(128, 50);
         begin
            for (int i = 0; i < 400 && cap_q.size() < base + 32; i++) begin
               RxReady = 1'($urandom_range(0, 1));
               @(posedge SysClk);
               #1;
            end
         end
      join
      RxReady = 1'b1;
      repeat (20) @(posedge SysClk);
      #1;
      total++; if (cap_q.size() != base + 32) begin bad++; $display("FAIL rnd_count got=%0d exp=32", cap_q.size() - base); end
      for (int b = 0; b < 32 && base + b < cap_q.size(); b++) begin
         e = {b == 0, b == 31, 4'hF, exp_word(50, b), 16'd128};
         total++;
         if (cap_q[base + b] !== e) begin bad++; $display("FAIL rnd_beat b=%0d got=%h exp=%h", b, cap_q[base + b], e); end
      end
      total++; if (stall_err != s0) begin bad++; $display("FAIL rnd_stall_stable got=%0d exp=0", stall_err - s0); end
   endtask

   task automatic test_reset_mid_output();
      int base, n_after, v0;
      base = cap_q.size();
      RxReady = 1'b1;
      send_frame(128, 60);
      wait_beats(base + 8, 100);
      Rst = 1'b1;
      @(posedge SysClk);
      #1;
      total++; if (RxValid !== 1'b0) begin bad++; $display("FAIL rstmid_RxValid got=%0h exp=0", RxValid); end
      total++; if (RxData !== 32'h0) begin bad++; $display("FAIL rstmid_RxData got=%h exp=0", RxData); end
      total++; if ({RxSop, RxEop, RxKeep} !== 6'h0) begin bad++; $display("FAIL rstmid_ctrl got=%h exp=0", {RxSop, RxEop, RxKeep}); end
      total++; if (RxLen !== 16'h0) begin bad++; $display("FAIL rstmid_RxLen got=%h exp=0", RxLen); end
      Rst = 1'b0;
      n_after = cap_q.size();
      v0      = valid_cnt;
      repeat (60) @(posedge SysClk);
      #1;
      total++; if (n_after >= base + 32) begin bad++; $display("FAIL rstmid_truncated got=%0d exp=<32", n_after - base); end
      total++; if (cap_q.size() != n_after) begin bad++; $display("FAIL rstmid_residual got=%0d exp=0", cap_q.size() - n_after); end
      total++; if (valid_cnt != v0) begin bad++; $display("FAIL rstmid_valid_after got=%0d exp=0", valid_cnt - v0); end
   endtask

   initial begin
      Rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;
      RxReady       = 1'b1;
`ifdef RX_PKT_STAT_EN
      CntClr        = 1'b0;
`endif
      do_reset();
      test_reset();
      test_frame_64();
      test_frame_65();
      test_back_to_back();
      test_runt_oversize();
      test_fill();
      test_random_ready();
      test_reset_mid_output();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
